// File: rtl/params_pkg.sv
// Project-wide architectural parameters shared by the EX-path units.
package params_pkg;
    parameter int REGISTER_WIDTH = 5;
endpackage

// File: rtl/mul_pipeline.sv
// Fixed four-stage RV32M multiplier (MUL/MULH/MULHSU/MULHU). It publishes per-stage
// occupancy so decode can detect RAW and writeback-port hazards.
module mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      issue_valid_i,
    input  logic [2:0]                issue_funct3_i,
    input  logic [DATA_WIDTH-1:0]     issue_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     issue_rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] issue_wr_reg_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      wb_is_next_cycle_o,
    output logic                      wb_valid_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o
);
    localparam int OW = DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;

    logic [3:0]                valid_q;
    logic [3:0]                hi_q;
    logic [REGISTER_WIDTH-1:0] rd_q [4];
    logic [OW-1:0]             a_q;
    logic [OW-1:0]             b_q;
    logic [PW-1:0]             p2_q;
    logic [PW-1:0]             p3_q;
    logic [PW-1:0]             p4_q;

    logic                      a_signed;
    logic                      b_signed;
    logic                      sel_hi;
    logic [OW-1:0]             a_ext;
    logic [OW-1:0]             b_ext;
    logic [PW-1:0]             a_wide;
    logic [PW-1:0]             b_wide;
    logic [PW-1:0]             product;

    // funct3 1xx decodes as plain MUL: unsigned operands, low half selected.
    always_comb begin
        a_signed = (issue_funct3_i == 3'b001) || (issue_funct3_i == 3'b010);
        b_signed = (issue_funct3_i == 3'b001);
        sel_hi   = !issue_funct3_i[2] && (issue_funct3_i[1:0] != 2'b00);
        a_ext    = {a_signed & issue_rs1_data_i[DATA_WIDTH-1], issue_rs1_data_i};
        b_ext    = {b_signed & issue_rs2_data_i[DATA_WIDTH-1], issue_rs2_data_i};
    end

    // Only the low 2*DATA_WIDTH bits of the extended product are ever selected.
    always_comb begin
        a_wide  = {{(DATA_WIDTH-1){a_q[OW-1]}}, a_q};
        b_wide  = {{(DATA_WIDTH-1){b_q[OW-1]}}, b_q};
        product = a_wide * b_wide;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            hi_q    <= '0;
            for (int i = 0; i < 4; i++) rd_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            p4_q    <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (!stall_i) begin
            valid_q <= {valid_q[2:0], issue_valid_i && (issue_wr_reg_i != '0)};
            hi_q    <= {hi_q[2:0], sel_hi};
            rd_q[0] <= issue_wr_reg_i;
            rd_q[1] <= rd_q[0];
            rd_q[2] <= rd_q[1];
            rd_q[3] <= rd_q[2];
            a_q     <= a_ext;
            b_q     <= b_ext;
            p2_q    <= product;
            p3_q    <= p2_q;
            p4_q    <= p3_q;
        end
    end

    assign ex1_valid_o        = valid_q[0];
    assign ex2_valid_o        = valid_q[1];
    assign ex3_valid_o        = valid_q[2];
    assign ex4_valid_o        = valid_q[3];
    assign ex1_wr_reg_o       = rd_q[0];
    assign ex2_wr_reg_o       = rd_q[1];
    assign ex3_wr_reg_o       = rd_q[2];
    assign ex4_wr_reg_o       = rd_q[3];
    assign wb_is_next_cycle_o = valid_q[2] && !stall_i;
    assign wb_valid_o         = valid_q[3] && !stall_i;
    assign wb_wr_reg_o        = rd_q[3];
    assign wb_data_o          = hi_q[3] ? p4_q[PW-1:DATA_WIDTH] : p4_q[DATA_WIDTH-1:0];

    // Decode must never issue while stalled, and only funct3 0xx is legal.
    issue_during_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue_valid_i && stall_i));
    illegal_funct3: assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_valid_i |-> !issue_funct3_i[2]);
endmodule
